// File: rtl/bp_pht_ctrl.sv
// bp_pht_ctrl: pattern history table of 2-bit counters with lookup-priority port and queued EX updates.
// Optional BP_GSHARE_EN folds a global history register into the table index.
module bp_pht_ctrl #(
  parameter int IDX_W = 6,
  parameter int QDEPTH = 4,
  parameter logic [1:0] INIT_STATE = 2'b01,
  parameter int GHR_W = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        lk_valid,
  input  logic [31:0]                 lk_pc,
  output logic                        lk_pred_valid,
  output logic                        lk_pred,
  input  logic                        up_valid,
  input  logic [31:0]                 up_pc,
  input  logic                        up_taken,
  output logic                        up_ready,
  input  logic                        flush,
  output logic                        busy,
  output logic [$clog2(QDEPTH):0]     q_count
);
  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int PW = $clog2(QDEPTH);
  localparam int N = 2 ** IDX_W;
  typedef enum logic {S_INIT, S_RUN} state_t;
  state_t state, state_nxt;
  logic [IDX_W-1:0] sweep_idx, lk_idx, up_idx, pop_idx;
  logic [1:0] pht [N];
  logic [IDX_W:0] q [QDEPTH];
  logic [PW-1:0] head, tail;
  logic push, pop;
  logic [1:0] cur, upd;
  logic unused;
`ifdef BP_GSHARE_EN
  logic [GHR_W-1:0] ghr;
  assign lk_idx = lk_pc[IDX_W+1:2] ^ ghr[IDX_W-1:0];
  assign up_idx = up_pc[IDX_W+1:2] ^ ghr[IDX_W-1:0];
  always_ff @(posedge clk or negedge rst)
    if (!rst) ghr <= '0;
    else if (flush) ghr <= '0;
    else if (push) ghr <= {ghr[GHR_W-2:0], up_taken};
`else
  assign lk_idx = lk_pc[IDX_W+1:2];
  assign up_idx = up_pc[IDX_W+1:2];
`endif
  assign unused = ^{lk_pc[31:IDX_W+2], lk_pc[1:0], up_pc[31:IDX_W+2], up_pc[1:0], GHR_W >= IDX_W};
  assign busy = state == S_INIT;
  assign up_ready = !busy && q_count != CW'(QDEPTH);
  assign push = up_valid && up_ready;
  // Lookups own the table port, so the queue drains only on idle cycles.
  assign pop = !busy && q_count != '0 && !lk_valid && !flush;
  assign pop_idx = q[head][IDX_W:1];
  assign cur = pht[pop_idx];
  assign upd = q[head][0] ? (cur == 2'b11 ? cur : cur + 2'b01) : (cur == 2'b00 ? cur : cur - 2'b01);
  always_comb begin
    state_nxt = state;
    if (flush) state_nxt = S_INIT;
    else if (busy && sweep_idx == IDX_W'(N - 1)) state_nxt = S_RUN;
  end
  always_ff @(posedge clk)
    if (busy) pht[sweep_idx] <= INIT_STATE;
    else if (pop) pht[pop_idx] <= upd;
  always_ff @(posedge clk)
    if (push) q[tail] <= {up_idx, up_taken};
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= S_INIT;
      sweep_idx <= '0;
      head <= '0;
      tail <= '0;
      q_count <= '0;
      lk_pred_valid <= 1'b0;
      lk_pred <= 1'b0;
    end else begin
      state <= state_nxt;
      sweep_idx <= flush ? '0 : busy ? sweep_idx + 1'b1 : sweep_idx;
      lk_pred_valid <= lk_valid;
      lk_pred <= lk_valid && !busy && pht[lk_idx][1];
      if (flush) begin
        head <= '0;
        tail <= '0;
        q_count <= '0;
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop) head <= head + 1'b1;
        q_count <= q_count + CW'(push) - CW'(pop);
      end
    end
endmodule
